branch_hazard_ctrl: RTL

Sequencing controller for the ID-stage branch resolver of the five-stage MIPS pipeline. It decides when a BEQ/BNE sitting in ID may be resolved, stalls IF/ID and injects bubbles into ID/EX until its operands are forwardable, selects the comparator operand sources, and issues the taken/flush decision. It also keeps saturating taken-branch and stall-cycle counters for the debug unit.

---
 rtl/branch_hazard_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Sequences the ID-stage BEQ/BNE resolver of the five-stage pipeline. It
//   stalls IF/ID and bubbles ID/EX until the branch operands can be forwarded
//   to the ID comparator. It selects the comparator operand sources and issues
//   the taken/flush decision. It also keeps saturating statistics counters.
//
// Ports
//   clk_i, reset_i          pipeline clock, asynchronous active-high reset
//   halt_i                  debug freeze, holds all state
//   branch_op_i             00 none, 01 BEQ, 10 BNE, 11 none
//   rs_i, rt_i              branch source registers
//   is_equal_i              comparator result, computed on forwarded operands
//   ex_*/mem_*/wb_*         destination/write/load info of in-flight producers
//   stall_o, bubble_o       freeze PC and IF/ID, inject NOP into ID/EX
//   fwd_a_o, fwd_b_o        operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   pc_src_o, flush_if_o    take the branch target, squash the fetched instr
//   taken_cnt_o, stall_cnt_o saturating statistics
//
// state   | meaning
// IDLE    | no branch pending, or a hazard-free branch resolving this cycle
// STALL   | load-in-EX hazard, first of two stall cycles already done
// RESOLVE | operands now forwardable, branch resolves this cycle

module branch_hazard_ctrl #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              halt_i,
    input  logic [1:0]        branch_op_i,
    input  logic [NB_REG-1:0] rs_i,
    input  logic [NB_REG-1:0] rt_i,
    input  logic              is_equal_i,
    input  logic [NB_REG-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [NB_REG-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    input  logic [NB_REG-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              pc_src_o,
    output logic              flush_if_o,
    output logic [NB_CNT-1:0] taken_cnt_o,
    output logic [NB_CNT-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [1:0]  cnt, next_cnt;
    logic [1:0]  h_rs, h_rt, n_depth;
    logic        is_branch, taken, resolve;

    // Cycles the branch must wait before operand r is forwardable to ID.
    function automatic logic [1:0] hazard_depth(
        input logic [NB_REG-1:0] r,
        input logic [NB_REG-1:0] ex_rd,
        input logic              ex_rw,
        input logic              ex_mr,
        input logic [NB_REG-1:0] mem_rd,
        input logic              mem_rw,
        input logic              mem_mr
    );
        logic [1:0] h;
        h = 2'd0;
        if (r != '0) begin
            if (ex_rw && ex_mr && ex_rd == r)
                h = 2'd2;
            else if (ex_rw && ex_rd == r)
                h = 2'd1;
            else if (mem_rw && mem_mr && mem_rd == r)
                h = 2'd1;
        end
        return h;
    endfunction

    // EX/MEM ALU results take priority over older MEM/WB data.
    function automatic logic [1:0] fwd_sel(
        input logic [NB_REG-1:0] r,
        input logic [NB_REG-1:0] mem_rd,
        input logic              mem_rw,
        input logic              mem_mr,
        input logic [NB_REG-1:0] wb_rd,
        input logic              wb_rw
    );
        logic [1:0] f;
        f = 2'b00;
        if (r != '0) begin
            if (mem_rw && !mem_mr && mem_rd == r)
                f = 2'b01;
            else if (wb_rw && wb_rd == r)
                f = 2'b10;
        end
        return f;
    endfunction

    always_comb begin
        h_rs    = hazard_depth(rs_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
                               mem_rd_i, mem_regwrite_i, mem_memread_i);
        h_rt    = hazard_depth(rt_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
                               mem_rd_i, mem_regwrite_i, mem_memread_i);
        n_depth = (h_rs > h_rt) ? h_rs : h_rt;
        fwd_a_o = fwd_sel(rs_i, mem_rd_i, mem_regwrite_i, mem_memread_i,
                          wb_rd_i, wb_regwrite_i);
        fwd_b_o = fwd_sel(rt_i, mem_rd_i, mem_regwrite_i, mem_memread_i,
                          wb_rd_i, wb_regwrite_i);
    end

    assign is_branch = (branch_op_i == 2'b01) || (branch_op_i == 2'b10);
    assign taken     = ((branch_op_i == 2'b01) &&  is_equal_i) ||
                       ((branch_op_i == 2'b10) && !is_equal_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else if (!halt_i) begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall_o    = 1'b0;
        bubble_o   = 1'b0;
        resolve    = 1'b0;
        if (reset_i) begin
            next_state = IDLE;
            next_cnt   = 2'd0;
        end else if (halt_i) begin
            // Frozen pipeline: hold the front end, never resolve.
            stall_o = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (is_branch) begin
                        if (n_depth == 2'd0) begin
                            resolve = 1'b1;
                        end else begin
                            stall_o    = 1'b1;
                            bubble_o   = 1'b1;
                            next_cnt   = n_depth - 2'd1;
                            next_state = (n_depth == 2'd2) ? STALL : RESOLVE;
                        end
                    end
                end
                STALL: begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    if (cnt != 2'd0)
                        next_cnt = cnt - 2'd1;
                    // cnt==0 cannot occur here; treat it as done rather than hang.
                    if (cnt <= 2'd1)
                        next_state = RESOLVE;
                end
                RESOLVE: begin
                    resolve    = 1'b1;
                    next_cnt   = 2'd0;
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = 2'd0;
                end
            endcase
        end
        pc_src_o   = resolve && taken;
        flush_if_o = resolve && taken;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            taken_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (!halt_i) begin
            if (pc_src_o && taken_cnt_o != '1)
                taken_cnt_o <= taken_cnt_o + 1'b1;
            if (stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule
